// File: rtl/fpu_f32_to_int_pipe_if.sv
// Operand and result handshake bundle for the float-to-int converter.
// Valid/ready on both sides: a transfer happens on the rising CLK edge where VALID and READY are both 1.
interface fpu_f32_to_int_pipe_if;
    logic        A_VALID;
    logic        A_READY;
    logic [31:0] A;
    logic        A_SIGNED;
    logic        A_RNE;
    logic        O_VALID;
    logic        O_READY;
    logic [31:0] O;
    logic [1:0]  O_FLAGS;

    modport master (
        output A_VALID, A, A_SIGNED, A_RNE, O_READY,
        input  A_READY, O_VALID, O, O_FLAGS
    );

    modport slave (
        input  A_VALID, A, A_SIGNED, A_RNE, O_READY,
        output A_READY, O_VALID, O, O_FLAGS
    );
endinterface

// File: rtl/fpu_f32_to_int_pipe.sv
// Three-stage binary32 -> int32/uint32 converter: unpack/classify, align, round/sign/saturate.
// Each stage holds its contents until the next one can take them; A_READY is combinational from O_READY.
module fpu_f32_to_int_pipe (
    input  logic                     CLK,
    input  logic                     RST,
    fpu_f32_to_int_pipe_if.slave     bus
);
    logic adv1, adv2, adv3;

    logic        s1_valid, s1_sign, s1_signed, s1_rne;
    logic        s1_nan, s1_inf, s1_zero, s1_huge;
    logic [7:0]  s1_exp;
    logic [22:0] s1_frac;

    logic        s2_valid, s2_sign, s2_signed, s2_rne;
    logic        s2_nan, s2_inf, s2_huge, s2_guard, s2_sticky;
    logic [32:0] s2_mag;

    logic        o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_flags;

    assign adv3 = !o_valid || bus.O_READY;
    assign adv2 = !s2_valid || adv3;
    assign adv1 = !s1_valid || adv2;

    assign bus.A_READY = adv1;
    assign bus.O_VALID = o_valid;
    assign bus.O       = o_data;
    assign bus.O_FLAGS = o_flags;

    logic [7:0]  a_exp;
    logic [22:0] a_frac;
    logic        a_nan, a_inf, a_zero, a_huge;

    assign a_exp  = bus.A[30:23];
    assign a_frac = bus.A[22:0];
    assign a_nan  = (a_exp == 8'hFF) && (|a_frac);
    assign a_inf  = (a_exp == 8'hFF) && !(|a_frac);
    assign a_zero = (a_exp == 8'h00);
    assign a_huge = (a_exp != 8'hFF) && (a_exp >= (bus.A_SIGNED ? 8'd159 : 8'd160));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_signed <= 1'b0;
            s1_rne    <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_huge   <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
        end else if (adv1) begin
            s1_valid <= bus.A_VALID;
            if (bus.A_VALID) begin
                s1_sign   <= bus.A[31];
                s1_signed <= bus.A_SIGNED;
                s1_rne    <= bus.A_RNE;
                s1_nan    <= a_nan;
                s1_inf    <= a_inf;
                s1_zero   <= a_zero;
                s1_huge   <= a_huge;
                s1_exp    <= a_exp;
                s1_frac   <= a_frac;
            end
        end
    end

    // Align: the binary point of m sits 150 - e bits from its LSB.
    logic [23:0] m;
    logic [7:0]  lsh;
    logic [4:0]  rsh;
    logic [23:0] low_mask;
    logic [32:0] al_mag;
    logic        al_guard, al_sticky;

    assign m        = {1'b1, s1_frac};
    assign lsh      = s1_exp - 8'd150;
    assign rsh      = 5'(8'd150 - s1_exp);
    assign low_mask = (24'd1 << (rsh - 5'd1)) - 24'd1;

    always_comb begin
        al_mag    = '0;
        al_guard  = 1'b0;
        al_sticky = 1'b0;
        if (s1_zero) begin
            al_sticky = |s1_frac;
        end else if (s1_exp >= 8'd150) begin
            al_mag = {9'b0, m} << lsh;
        end else if (s1_exp >= 8'd127) begin
            al_mag    = {9'b0, m >> rsh};
            al_guard  = m[rsh - 5'd1];
            al_sticky = |(m & low_mask);
        end else begin
            al_guard  = (s1_exp == 8'd126);
            al_sticky = (s1_exp < 8'd126) || (|s1_frac);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_signed <= 1'b0;
            s2_rne    <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_huge   <= 1'b0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_mag    <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign   <= s1_sign;
                s2_signed <= s1_signed;
                s2_rne    <= s1_rne;
                s2_nan    <= s1_nan;
                s2_inf    <= s1_inf;
                s2_huge   <= s1_huge;
                s2_guard  <= al_guard;
                s2_sticky <= al_sticky;
                s2_mag    <= al_mag;
            end
        end
    end

    // Round, apply sign, saturate. Invalid results never also report inexact.
    logic        inc, inexact;
    logic [33:0] rmag;
    logic [31:0] r_data;
    logic [1:0]  r_flags;

    assign inc     = s2_rne && s2_guard && (s2_sticky || s2_mag[0]);
    assign rmag    = {1'b0, s2_mag} + {33'b0, inc};
    assign inexact = s2_guard || s2_sticky;

    always_comb begin
        r_data  = '0;
        r_flags = {1'b0, inexact};
        if (s2_nan) begin
            r_data  = s2_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            r_flags = 2'b10;
        end else if (s2_inf || s2_huge) begin
            r_flags = 2'b10;
            if (s2_sign) r_data = s2_signed ? 32'h8000_0000 : 32'h0000_0000;
            else         r_data = s2_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        end else if (s2_signed) begin
            if (!s2_sign && rmag > 34'h0_7FFF_FFFF) begin
                r_data  = 32'h7FFF_FFFF;
                r_flags = 2'b10;
            end else if (s2_sign && rmag > 34'h0_8000_0000) begin
                r_data  = 32'h8000_0000;
                r_flags = 2'b10;
            end else begin
                r_data = s2_sign ? (32'd0 - rmag[31:0]) : rmag[31:0];
            end
        end else begin
            if (s2_sign) begin
                if (rmag != 34'd0) r_flags = 2'b10;
            end else if (rmag > 34'h0_FFFF_FFFF) begin
                r_data  = 32'hFFFF_FFFF;
                r_flags = 2'b10;
            end else begin
                r_data = rmag[31:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_flags <= '0;
        end else if (adv3) begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_data  <= r_data;
                o_flags <= r_flags;
            end
        end
    end
endmodule

// File: tb/tb_fpu_f32_to_int_pipe.sv
// Bench for fpu_f32_to_int_pipe: directed conversions, randomized streams with back-pressure, mid-stream reset.
// Expected results come from a real-arithmetic reference model or from hand-derived constants.
module tb_fpu_f32_to_int_pipe;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fpu_f32_to_int_pipe_if bus();

    fpu_f32_to_int_pipe dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic        sg;
        logic        rne;
        logic        use_exp;
        logic [33:0] exp;
    } stim_t;

    stim_t       in_q[$];
    logic [33:0] exp_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_ov = -1;
    int          last_emit = -1;
    logic        hold = 1'b0;
    logic [33:0] held = '0;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: value = m * 2^(e-150) as a real, then round and clamp to the integer range.
    function automatic logic [33:0] model(input logic [31:0] a, input logic sg, input logic rne);
        logic   neg;
        int     e;
        int     fr;
        real    mag, fl, rem, r;
        logic   inex;
        longint v;
        neg = a[31];
        e   = int'(a[30:23]);
        fr  = int'(a[22:0]);
        if (e == 255) begin
            if (fr != 0) return {2'b10, (sg ? 32'h7FFFFFFF : 32'hFFFFFFFF)};
            if (neg)     return {2'b10, (sg ? 32'h80000000 : 32'h00000000)};
            return {2'b10, (sg ? 32'h7FFFFFFF : 32'hFFFFFFFF)};
        end
        if (e == 0) return {1'b0, (fr != 0), 32'h0};
        mag = 8388608.0 + real'(fr);
        if (e > 150) for (int i = 0; i < e - 150; i++) mag = mag * 2.0;
        else         for (int i = 0; i < 150 - e; i++) mag = mag / 2.0;
        fl   = $floor(mag);
        rem  = mag - fl;
        inex = (rem != 0.0);
        r    = fl;
        if (rne && (rem > 0.5 || (rem == 0.5 && (fl - 2.0 * $floor(fl / 2.0)) == 1.0))) r = fl + 1.0;
        if (sg) begin
            if (!neg && r > 2147483647.0) return {2'b10, 32'h7FFFFFFF};
            if (neg && r > 2147483648.0)  return {2'b10, 32'h80000000};
            v = longint'(r);
            if (neg) v = -v;
            return {1'b0, inex, v[31:0]};
        end
        if (neg) return (r != 0.0) ? {2'b10, 32'h0} : {1'b0, inex, 32'h0};
        if (r > 4294967295.0) return {2'b10, 32'hFFFFFFFF};
        v = longint'(r);
        return {1'b0, inex, v[31:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] a;
        logic [7:0]  e;
        a = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: begin
                e = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                a[30:23] = e;
                if ($urandom_range(0, 1) != 0) a[22:0] = '0;
            end
            default: begin
                a[30:23] = 8'($urandom_range(120, 162));
                if ($urandom_range(0, 1) != 0) a[10:0] = '0;
            end
        endcase
        return a;
    endfunction

    task automatic push_rand(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s.a       = rand_operand();
            s.sg      = 1'($urandom_range(0, 1));
            s.rne     = 1'($urandom_range(0, 1));
            s.use_exp = 1'b0;
            s.exp     = '0;
            in_q.push_back(s);
        end
    endtask

    task automatic push_dir(input logic [31:0] a, input logic sg, input logic rne,
                            input logic [31:0] res, input logic [1:0] flags);
        stim_t s;
        s.a       = a;
        s.sg      = sg;
        s.rne     = rne;
        s.use_exp = 1'b1;
        s.exp     = {flags, res};
        in_q.push_back(s);
    endtask

    // One cycle: inputs already driven; sample at negedge, then step past the rising edge.
    task automatic tick();
        stim_t s;
        @(negedge CLK);
        if (hold) begin
            check("hold_valid", 34'(bus.O_VALID), 34'd1);
            check("hold_data", {bus.O_FLAGS, bus.O}, held);
        end
        check("a_ready", 34'(bus.A_READY), 34'(!(exp_q.size() == 3 && !bus.O_READY)));
        if (bus.O_VALID && first_ov < 0) first_ov = cyc;
        if (bus.O_VALID && bus.O_READY) begin
            check("emit_expected", 34'(exp_q.size() != 0), 34'd1);
            if (exp_q.size() != 0) check("result", {bus.O_FLAGS, bus.O}, exp_q.pop_front());
            last_emit = cyc;
        end
        if (bus.A_VALID && bus.A_READY) begin
            s = in_q.pop_front();
            exp_q.push_back(s.use_exp ? s.exp : model(s.a, s.sg, s.rne));
            if (first_acc < 0) first_acc = cyc;
        end
        hold = bus.O_VALID && !bus.O_READY;
        held = {bus.O_FLAGS, bus.O};
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive_inputs(input logic want);
        bus.A_VALID = want && (in_q.size() != 0);
        if (in_q.size() != 0) begin
            bus.A        = in_q[0].a;
            bus.A_SIGNED = in_q[0].sg;
            bus.A_RNE    = in_q[0].rne;
        end else begin
            bus.A        = $urandom;
            bus.A_SIGNED = 1'($urandom_range(0, 1));
            bus.A_RNE    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_stream(input logic rand_ready, input logic gaps, input int budget);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            drive_inputs(!gaps || ($urandom_range(0, 3) != 0));
            bus.O_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("stream_drained", 34'(in_q.size() + exp_q.size()), 34'd0);
        bus.A_VALID = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        bus.A_VALID  = 1'b0;
        bus.A        = '0;
        bus.A_SIGNED = 1'b0;
        bus.A_RNE    = 1'b0;
        bus.O_READY  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_o_valid", 34'(bus.O_VALID), 34'd0);
        check("rst_o", 34'(bus.O), 34'd0);
        check("rst_o_flags", 34'(bus.O_FLAGS), 34'd0);
        RST = 1'b0;
        #1;
        check("rel_a_ready", 34'(bus.A_READY), 34'd1);

        // Directed conversions.
        push_dir(32'h3FC00000, 1'b1, 1'b1, 32'd2,         2'b01);
        push_dir(32'h3FC00000, 1'b1, 1'b0, 32'd1,         2'b01);
        push_dir(32'h40200000, 1'b1, 1'b1, 32'd2,         2'b01);
        push_dir(32'h3F000000, 1'b1, 1'b1, 32'd0,         2'b01);
        push_dir(32'h42F60000, 1'b1, 1'b1, 32'd123,       2'b00);
        push_dir(32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF,  2'b10);
        push_dir(32'hCF000000, 1'b1, 1'b0, 32'h80000000,  2'b00);
        push_dir(32'hFF800000, 1'b1, 1'b0, 32'h80000000,  2'b10);
        push_dir(32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF,  2'b10);
        push_dir(32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00,  2'b00);
        push_dir(32'hBF800000, 1'b0, 1'b0, 32'd0,         2'b10);
        push_dir(32'hBE99999A, 1'b0, 1'b0, 32'd0,         2'b01);
        push_dir(32'h7FC00000, 1'b0, 1'b0, 32'hFFFFFFFF,  2'b10);
        push_dir(32'h80000000, 1'b1, 1'b1, 32'd0,         2'b00);
        push_dir(32'hBF000000, 1'b0, 1'b1, 32'd0,         2'b01);
        push_dir(32'hCF000001, 1'b1, 1'b0, 32'h80000000,  2'b10);
        run_stream(1'b0, 1'b0, 200);

        // Back-to-back burst: latency and full throughput.
        repeat (4) tick();
        first_acc = -1;
        first_ov  = -1;
        last_emit = -1;
        push_rand(16);
        run_stream(1'b0, 1'b0, 200);
        check("latency", 34'(first_ov - first_acc), 34'd3);
        check("burst_rate", 34'(last_emit - first_ov), 34'd15);

        // Same traffic under random back-pressure, then with input gaps too.
        push_rand(16);
        run_stream(1'b1, 1'b0, 400);
        push_rand(300);
        run_stream(1'b1, 1'b1, 4000);

        // Reset with three operands in flight.
        push_rand(3);
        bus.O_READY = 1'b0;
        for (int i = 0; i < 10 && in_q.size() != 0; i++) begin
            drive_inputs(1'b1);
            tick();
        end
        check("inflight_count", 34'(exp_q.size()), 34'd3);
        bus.A_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_o_valid", 34'(bus.O_VALID), 34'd0);
        check("async_rst_o", 34'(bus.O), 34'd0);
        check("async_rst_o_flags", 34'(bus.O_FLAGS), 34'd0);
        exp_q.delete();
        in_q.delete();
        hold = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("post_rst_a_ready", 34'(bus.A_READY), 34'd1);
        push_dir(32'h41200000, 1'b1, 1'b0, 32'd10, 2'b00);
        run_stream(1'b0, 1'b0, 50);
        bus.O_READY = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
